// File: rtl/led_test_pkg.sv
// Shared types and constants for the LED gate checker.
// State encoding, error-mask bit positions and default dwell.
package led_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int unsigned DWELL_DEFAULT = 100;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned NUM_GATES = 6;

  localparam int unsigned ERR_AND  = 0;
  localparam int unsigned ERR_NAND = 1;
  localparam int unsigned ERR_OR   = 2;
  localparam int unsigned ERR_NOR  = 3;
  localparam int unsigned ERR_XOR  = 4;
  localparam int unsigned ERR_INV  = 5;

  localparam logic [1:0] VEC_LAST    = 2'd3;
  localparam logic [2:0] ERR_CNT_MAX = 3'd4;

  typedef logic [NUM_GATES-1:0] gate_vec_t;

  function automatic gate_vec_t pack_gates(
    input logic g_and,
    input logic g_nand,
    input logic g_or,
    input logic g_nor,
    input logic g_xor,
    input logic g_inv
  );
    gate_vec_t v;
    v           = '0;
    v[ERR_AND]  = g_and;
    v[ERR_NAND] = g_nand;
    v[ERR_OR]   = g_or;
    v[ERR_NOR]  = g_nor;
    v[ERR_XOR]  = g_xor;
    v[ERR_INV]  = g_inv;
    return v;
  endfunction

endpackage

// File: rtl/led_gate_checker_if.sv
// Bundle between the gate checker and the LED block under test.
// master = checker side, slave = LED block / observer side.
interface led_gate_checker_if;
  import led_test_pkg::*;

  logic       start;
  logic       g_and;
  logic       g_nand;
  logic       g_or;
  logic       g_nor;
  logic       g_xor;
  logic       g_inv;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  gate_vec_t  err_mask;
  logic [2:0] err_cnt;
  logic [1:0] vec;

  modport master (
    input  start,
    input  g_and, g_nand, g_or,
    input  g_nor, g_xor, g_inv,
    output a, b, busy, done, pass,
    output err_mask, err_cnt, vec
  );

  modport slave (
    output start,
    output g_and, g_nand, g_or,
    output g_nor, g_xor, g_inv,
    input  a, b, busy, done, pass,
    input  err_mask, err_cnt, vec
  );

endinterface

// File: rtl/gate_ref_model.sv
// Golden gate responses for one stimulus pair (a, b).
// Bit order matches the error mask.
module gate_ref_model
  import led_test_pkg::*;
(
  input  logic      a,
  input  logic      b,
  output gate_vec_t exp_o
);

  always_comb begin
    exp_o           = '0;
    exp_o[ERR_AND]  = a & b;
    exp_o[ERR_NAND] = ~(a & b);
    exp_o[ERR_OR]   = a | b;
    exp_o[ERR_NOR]  = ~(a | b);
    exp_o[ERR_XOR]  = a ^ b;
    exp_o[ERR_INV]  = ~a;
  end

endmodule

// File: rtl/led_gate_checker.sv
// Walks a,b through 00..11, dwells, samples the LED block's
// gate outputs and accumulates sticky per-gate mismatches.
module led_gate_checker
  import led_test_pkg::*;
#(
  parameter int unsigned DWELL = DWELL_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_and,
  input  logic       i_nand,
  input  logic       i_or,
  input  logic       i_nor,
  input  logic       i_xor,
  input  logic       i_inv,
  output logic       o_a,
  output logic       o_b,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output gate_vec_t  o_err_mask,
  output logic [2:0] o_err_cnt,
  output logic [1:0] o_vec
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(DWELL - 1);

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  gate_vec_t        mask_q, mask_d;
  logic [2:0]       ecnt_q, ecnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  gate_vec_t exp_w;
  gate_vec_t obs_w;
  gate_vec_t miss_w;

  gate_ref_model u_ref (
    .a     (vec_q[1]),
    .b     (vec_q[0]),
    .exp_o (exp_w)
  );

  assign obs_w = pack_gates(
    i_and, i_nand, i_or,
    i_nor, i_xor, i_inv
  );
  assign miss_w = obs_w ^ exp_w;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    ecnt_d  = ecnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d = ST_DRIVE;
          vec_d   = '0;
          cnt_d   = CNT_LOAD;
          mask_d  = '0;
          ecnt_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SAMPLE: begin
        mask_d = mask_q | miss_w;
        // saturating: at most one bump per vector
        if ((|miss_w) && (ecnt_q != ERR_CNT_MAX)) begin
          ecnt_d = ecnt_q + 3'd1;
        end
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRIVE;
          vec_d   = vec_q + 2'd1;
          cnt_d   = CNT_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      ecnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      ecnt_q  <= ecnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_a        = vec_q[1];
  assign o_b        = vec_q[0];
  assign o_vec      = vec_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err_mask = mask_q;
  assign o_err_cnt  = ecnt_q;
  assign o_pass     = done_q & (ecnt_q == 3'd0);

endmodule

// File: tb/tb_led_gate_checker.sv
// Bench for led_gate_checker with a behavioural LED block
// whose faults are injected per scenario.
module tb_led_gate_checker;
  import led_test_pkg::*;

  localparam int DW  = 4;
  localparam int RUN = 4 * (DW + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  led_gate_checker_if ifc ();

  int total = 0;
  int bad   = 0;
  int mode  = 0;
  logic [5:0] flips [4];
  logic [5:0] led_r;

  always_comb begin
    led_r = {~ifc.a, ifc.a ^ ifc.b,
             ~(ifc.a | ifc.b), ifc.a | ifc.b,
             ~(ifc.a & ifc.b), ifc.a & ifc.b};
    if (mode == 1) led_r[4] = 1'b0;
    if (mode == 2) led_r[5] = ~ifc.b;
    led_r = led_r ^ flips[{ifc.a, ifc.b}];
  end

  assign ifc.g_and  = led_r[0];
  assign ifc.g_nand = led_r[1];
  assign ifc.g_or   = led_r[2];
  assign ifc.g_nor  = led_r[3];
  assign ifc.g_xor  = led_r[4];
  assign ifc.g_inv  = led_r[5];

  led_gate_checker #(.DWELL(DW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (ifc.start),
    .i_and      (ifc.g_and),
    .i_nand     (ifc.g_nand),
    .i_or       (ifc.g_or),
    .i_nor      (ifc.g_nor),
    .i_xor      (ifc.g_xor),
    .i_inv      (ifc.g_inv),
    .o_a        (ifc.a),
    .o_b        (ifc.b),
    .o_busy     (ifc.busy),
    .o_done     (ifc.done),
    .o_pass     (ifc.pass),
    .o_err_mask (ifc.err_mask),
    .o_err_cnt  (ifc.err_cnt),
    .o_vec      (ifc.vec)
  );

  function automatic logic [16:0] outs();
    return {ifc.a, ifc.b, ifc.busy, ifc.done,
            ifc.pass, ifc.err_mask, ifc.err_cnt,
            ifc.vec};
  endfunction

  task automatic clear_flips();
    for (int v = 0; v < 4; v++) flips[v] = '0;
  endtask

  task automatic run_check(
    input string      nm,
    input int         poke_at,
    input logic [5:0] exp_mask,
    input logic [2:0] exp_cnt
  );
    logic [1:0] ev;
    logic [5:0] got;
    logic [5:0] want;
    @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= RUN; k++) begin
      ifc.start = (k == poke_at);
      ev   = (k < RUN) ? 2'(k / (DW + 1)) : 2'd3;
      want = {k < RUN, k == RUN, ev, ev[1], ev[0]};
      got  = {ifc.busy, ifc.done, ifc.vec,
              ifc.a, ifc.b};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s seq k=%0d got=%b want=%b",
                 nm, k, got, want);
      end
      if (k == 0) begin
        total++;
        if ({ifc.err_mask, ifc.err_cnt} !== 9'd0) begin
          bad++;
          $display("FAIL %s clear got=%b/%0d want=0/0",
                   nm, ifc.err_mask, ifc.err_cnt);
        end
      end
      if (k < RUN) @(negedge clk);
    end
    ifc.start = 1'b0;
    total++;
    if (ifc.err_mask !== exp_mask) begin
      bad++;
      $display("FAIL %s mask got=%b want=%b",
               nm, ifc.err_mask, exp_mask);
    end
    total++;
    if (ifc.err_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL %s cnt got=%0d want=%0d",
               nm, ifc.err_cnt, exp_cnt);
    end
    total++;
    if (ifc.pass !== (exp_cnt == 3'd0)) begin
      bad++;
      $display("FAIL %s pass got=%b want=%b",
               nm, ifc.pass, exp_cnt == 3'd0);
    end
  endtask

  task automatic test_reset();
    ifc.start = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (outs() !== 17'd0) begin
      bad++;
      $display("FAIL reset got=%h want=0", outs());
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (outs() !== 17'd0) begin
      bad++;
      $display("FAIL idle got=%h want=0", outs());
    end
  endtask

  task automatic test_correct();
    mode = 0;
    clear_flips();
    run_check("correct", -1, 6'b000000, 3'd0);
  endtask

  task automatic test_xor_stuck();
    mode = 1;
    clear_flips();
    run_check("xor_stuck", -1, 6'b010000, 3'd2);
  endtask

  task automatic test_inv_wrong();
    mode = 2;
    clear_flips();
    run_check("inv_b", -1, 6'b100000, 3'd2);
  endtask

  task automatic test_recover();
    mode = 0;
    clear_flips();
    run_check("recover", -1, 6'b000000, 3'd0);
  endtask

  task automatic test_start_ignored();
    mode = 0;
    clear_flips();
    run_check("restart", 11, 6'b000000, 3'd0);
  endtask

  task automatic test_reset_mid();
    mode = 0;
    clear_flips();
    flips[0] = 6'b000001;
    @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if (ifc.err_mask !== 6'b000001) begin
      bad++;
      $display("FAIL mid_pre mask got=%b want=000001",
               ifc.err_mask);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (outs() !== 17'd0) begin
      bad++;
      $display("FAIL mid_rst got=%h want=0", outs());
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (outs() !== 17'd0) begin
        bad++;
        $display("FAIL mid_quiet c=%0d got=%h want=0",
                 c, outs());
      end
    end
    clear_flips();
  endtask

  task automatic test_random();
    logic [5:0] em;
    logic [2:0] ec;
    mode = 3;
    for (int r = 0; r < 6; r++) begin
      em = '0;
      ec = '0;
      for (int v = 0; v < 4; v++) begin
        if ($urandom_range(0, 2) == 0) flips[v] = '0;
        else flips[v] = 6'($urandom);
        em = em | flips[v];
        if (flips[v] != 6'd0) ec = ec + 3'd1;
      end
      run_check($sformatf("rand%0d", r), -1, em, ec);
    end
    mode = 0;
    clear_flips();
  endtask

  initial begin
    ifc.start = 1'b0;
    clear_flips();
    test_reset();
    test_correct();
    test_xor_stuck();
    test_inv_wrong();
    test_recover();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_correct();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
